data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Load/store access controller between the execute stage and the synchronous data memory. It accepts one load or store per handshake and checks alignment. For stores it produces word-aligned addresses, byte enables and replicated write data. It runs the request/grant/response handshake with memory and bounds the wait with a timeout. For loads it registers the returned word together with the matching op and byte offset, and drives them directly into the load-extension stage (`Lw_Sw_OP`, `Byte_Loc`, `Data_Mem_Read` inputs of that stage).

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `TIMEOUT`, 255: maximum WAIT cycles before an access is aborted with error; must be ≥1.

Ports:
- `Clk` in 1: single clock, all state on rising edge.
- `Rst_N` in 1: reset, asynchronous, active-low.
- `Req_Valid` in 1: core presents an access.
- `Req_Ready` out 1: high iff state is IDLE.
- `Req_Write` in 1: 1 = store, 0 = load.
- `Req_Op` in 3: loads use 0=LB, 1=LH, 2=LW, 3=LBU, 4=LHU. Stores use 0=SB, 1=SH, 2=SW.
- `Req_Addr` in ADDR_WIDTH: byte address.
- `Req_Wdata` in 32: store data, right-aligned.
- `Mem_Req` out 1: request to memory, held until granted.
- `Mem_We` out 1: write strobe qualifier.
- `Mem_Be` out 4: byte enables.
- `Mem_Addr` out ADDR_WIDTH: word address, bits [1:0] always 0.
- `Mem_Wdata` out 32: lane-replicated store data.
- `Mem_Gnt` in 1: memory accepted `Mem_Req` this cycle.
- `Mem_Rvalid` in 1: read data valid, or write acknowledged.
- `Mem_Rdata` in 32: read word.
- `Rsp_Valid` out 1: one-cycle completion pulse.
- `Rsp_Err` out 1: valid with `Rsp_Valid`. Signals misaligned access, illegal op, or timeout.
- `Lw_Sw_OP` out 3: registered `Req_Op` of the access in flight or last completed.
- `Byte_Loc` out 2: registered `Req_Addr[1:0]`.
- `Data_Mem_Read` out 32: registered `Mem_Rdata`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - On `Req_Valid`: capture op, write, addr, wdata, and load `Lw_Sw_OP`/`Byte_Loc`.
  - If the access is legal, go to ISSUE; otherwise go to RESP with the error flag set.
- **Illegal access**, no memory traffic:
  - load op 5–7, or store op 3–7;
  - LH/LHU/SH with `Addr[0]`=1;
  - LW/SW with `Addr[1:0]`≠0.
- **ISSUE**
  - `Mem_Req`=1 with stable `Mem_We`/`Mem_Be`/`Mem_Addr`/`Mem_Wdata` until `Mem_Gnt`=1.
  - On grant, go to WAIT and clear the timeout counter.
- **WAIT**
  - `Mem_Req`=0. The counter increments each cycle.
  - `Mem_Rvalid`=1: for loads, capture `Mem_Rdata` into `Data_Mem_Read`. Go to RESP with no error.
  - If the counter reaches TIMEOUT with no `Mem_Rvalid`, go to RESP with error.
  - `Mem_Rvalid` in the same cycle the counter reaches TIMEOUT counts as success.
- **RESP**: `Rsp_Valid`=1 for exactly one cycle, `Rsp_Err` per flag, then IDLE.
- **Store formatting**
  - SB: `Mem_Be` = 1<<`Addr[1:0]`; `Mem_Wdata` = four copies of wdata[7:0].
  - SH: `Mem_Be` = `Addr[1]` ? 4'b1100 : 4'b0011; `Mem_Wdata` = two copies of wdata[15:0].
  - SW: `Mem_Be` = 4'b1111; `Mem_Wdata` = wdata.
- **Load formatting**: `Mem_Be` = 4'b1111 and `Mem_We`=0 for all loads.
- `Mem_Rvalid` and `Mem_Gnt` are ignored outside WAIT and ISSUE respectively.
- `Data_Mem_Read` updates only on a load's `Mem_Rvalid`. Stores and errors leave it unchanged.

## Timing
- **Reset values**: state IDLE, `Req_Ready`=1, counter 0. All of these outputs are 0: `Mem_Req`, `Mem_We`, `Mem_Be`, `Mem_Addr`, `Mem_Wdata`, `Rsp_Valid`, `Rsp_Err`, `Lw_Sw_OP`, `Byte_Loc`, `Data_Mem_Read`.
- **Registered outputs**: all memory-side and response outputs are registered. `Req_Ready` is decoded from the state.
- **Best-case legal access**:
  - cycle 0: accept;
  - cycle 1: `Mem_Req`, with `Mem_Gnt` high;
  - cycle 2: `Mem_Rvalid`;
  - cycle 3: `Rsp_Valid`, with `Data_Mem_Read` valid.
- **Latency**: every grant or response stall cycle adds one cycle.
- **Illegal access**: accept at cycle 0, `Rsp_Valid`+`Rsp_Err` at cycle 1.
- **Timeout**: grant at cycle g, `Rsp_Err` at cycle g+TIMEOUT+1.
- **Throughput**: next accept is no earlier than the cycle after `Rsp_Valid`. At most one access is outstanding.
- **Load-stage alignment**: `Lw_Sw_OP`/`Byte_Loc`/`Data_Mem_Read` are stable from the `Rsp_Valid` cycle until the next accept. The load stage's combinational output is therefore valid in the `Rsp_Valid` cycle.
- **Reset mid-operation**: `Rst_N` low in any state forces IDLE immediately. `Mem_Req` drops asynchronously, and no `Rsp_Valid` is produced for the aborted access.

## Test plan
- **LW**: `Req_Addr`=0x100, memory grants immediately and returns 0xDEADBEEF one cycle later. Expect:
  - `Mem_Addr`=0x100, `Mem_Be`=4'hF;
  - `Rsp_Valid` at cycle 3, `Rsp_Err`=0;
  - `Data_Mem_Read`=0xDEADBEEF, `Byte_Loc`=0, `Lw_Sw_OP`=2.
- **SB**: addr 0x203, wdata 0x000000A5. Expect:
  - `Mem_Addr`=0x200, `Mem_Be`=4'b1000, `Mem_Wdata`=0xA5A5A5A5, `Mem_We`=1.
- **SH**: addr 0x202. Expect `Mem_Be`=4'b1100. LH at addr 0x201 gives `Rsp_Err`=1 at cycle 1 with `Mem_Req` never asserted. Load op 6 behaves the same way.
- **Stalls**: `Mem_Gnt` low for 3 cycles, then `Mem_Rvalid` delayed 2 cycles, on an LBU at 0x1. Expect:
  - `Mem_Req` high for 4 cycles with constant outputs;
  - `Rsp_Valid` at cycle 7, `Byte_Loc`=1.
- **Timeout**: TIMEOUT=4, grant given, `Mem_Rvalid` never returns. Expect `Rsp_Err`=1 five cycles after grant. A late `Mem_Rvalid` in IDLE has no effect.
- **Reset mid-access**: assert `Rst_N` low in WAIT. Expect all outputs at reset values immediately, and a new request after release completes normally.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Core-side and memory-side handshake bundle for data_mem_ctrl.
// The controller takes core_slave and mem_master; the execute stage and the memory take the opposite modports.
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  Req_Valid;
  logic                  Req_Ready;
  logic                  Req_Write;
  logic [2:0]            Req_Op;
  logic [ADDR_WIDTH-1:0] Req_Addr;
  logic [31:0]           Req_Wdata;
  logic                  Rsp_Valid;
  logic                  Rsp_Err;

  logic                  Mem_Req;
  logic                  Mem_We;
  logic [3:0]            Mem_Be;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [31:0]           Mem_Wdata;
  logic                  Mem_Gnt;
  logic                  Mem_Rvalid;
  logic [31:0]           Mem_Rdata;

  modport core_master (
    output Req_Valid, Req_Write, Req_Op, Req_Addr, Req_Wdata,
    input  Req_Ready, Rsp_Valid, Rsp_Err
  );
  modport core_slave (
    input  Req_Valid, Req_Write, Req_Op, Req_Addr, Req_Wdata,
    output Req_Ready, Rsp_Valid, Rsp_Err
  );
  modport mem_master (
    output Mem_Req, Mem_We, Mem_Be, Mem_Addr, Mem_Wdata,
    input  Mem_Gnt, Mem_Rvalid, Mem_Rdata
  );
  modport mem_slave (
    input  Mem_Req, Mem_We, Mem_Be, Mem_Addr, Mem_Wdata,
    output Mem_Gnt, Mem_Rvalid, Mem_Rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store controller: one access in flight, 3-cycle best case (accept, request, response, Rsp_Valid), +1 per stall.
// Backpressure: Req_Ready only in IDLE; Mem_Req held until Mem_Gnt; response wait bounded by TIMEOUT.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic              Clk,
  input  logic              Rst_N,
  data_mem_ctrl_if.core_slave core,
  data_mem_ctrl_if.mem_master mem,
  output logic [2:0]        Lw_Sw_OP,
  output logic [1:0]        Byte_Loc,
  output logic [31:0]       Data_Mem_Read
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            byte_loc_q, byte_loc_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  legal;
  logic [3:0]            be_fmt;
  logic [31:0]           wdata_fmt;
  logic [CW-1:0]         cnt_inc;

  // Alignment / op legality of the request currently presented
  always_comb begin
    legal = 1'b0;
    if (core.Req_Write) begin
      case (core.Req_Op)
        3'd0:    legal = 1'b1;
        3'd1:    legal = ~core.Req_Addr[0];
        3'd2:    legal = (core.Req_Addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end else begin
      case (core.Req_Op)
        3'd0, 3'd3: legal = 1'b1;
        3'd1, 3'd4: legal = ~core.Req_Addr[0];
        3'd2:       legal = (core.Req_Addr[1:0] == 2'b00);
        default:    legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    be_fmt    = 4'hF;
    wdata_fmt = '0;
    if (core.Req_Write) begin
      case (core.Req_Op)
        3'd0: begin
          be_fmt    = 4'b0001 << core.Req_Addr[1:0];
          wdata_fmt = {4{core.Req_Wdata[7:0]}};
        end
        3'd1: begin
          be_fmt    = core.Req_Addr[1] ? 4'b1100 : 4'b0011;
          wdata_fmt = {2{core.Req_Wdata[15:0]}};
        end
        default: begin
          be_fmt    = 4'hF;
          wdata_fmt = core.Req_Wdata;
        end
      endcase
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    op_d        = op_q;
    byte_loc_d  = byte_loc_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (core.Req_Valid) begin
          op_d       = core.Req_Op;
          byte_loc_d = core.Req_Addr[1:0];
          if (legal) begin
            state_d     = ISSUE;
            mem_req_d   = 1'b1;
            mem_we_d    = core.Req_Write;
            mem_be_d    = be_fmt;
            mem_addr_d  = {core.Req_Addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = wdata_fmt;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (mem.Mem_Gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A response arriving on the last allowed cycle wins over the timeout
        if (mem.Mem_Rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          if (!mem_we_q) rdata_d = mem.Mem_Rdata;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_q        <= '0;
      byte_loc_q  <= '0;
      rdata_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      op_q        <= op_d;
      byte_loc_q  <= byte_loc_d;
      rdata_q     <= rdata_d;
    end
  end

  assign core.Req_Ready = (state_q == IDLE);
  assign core.Rsp_Valid = rsp_valid_q;
  assign core.Rsp_Err   = rsp_err_q;
  assign mem.Mem_Req    = mem_req_q;
  assign mem.Mem_We     = mem_we_q;
  assign mem.Mem_Be     = mem_be_q;
  assign mem.Mem_Addr   = mem_addr_q;
  assign mem.Mem_Wdata  = mem_wdata_q;
  assign Lw_Sw_OP       = op_q;
  assign Byte_Loc       = byte_loc_q;
  assign Data_Mem_Read  = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a response scoreboard and an inline memory responder.
// Inputs change and outputs are sampled on the falling edge.
module tb_data_mem_ctrl;

  localparam int AW = 32;
  localparam int TO = 4;

  logic        Clk;
  logic        Rst_N;
  logic [2:0]  Lw_Sw_OP;
  logic [1:0]  Byte_Loc;
  logic [31:0] Data_Mem_Read;

  data_mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  data_mem_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .Clk           (Clk),
    .Rst_N         (Rst_N),
    .core          (bus),
    .mem           (bus),
    .Lw_Sw_OP      (Lw_Sw_OP),
    .Byte_Loc      (Byte_Loc),
    .Data_Mem_Read (Data_Mem_Read)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        err;
    logic [2:0]  op;
    logic [1:0]  bl;
    logic [31:0] dmr;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] dmr_model = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.Req_Ready, 1);
    chk({tag, "_mreq"}, bus.Mem_Req, 0);
    chk({tag, "_we"}, bus.Mem_We, 0);
    chk({tag, "_be"}, bus.Mem_Be, 0);
    chk({tag, "_addr"}, bus.Mem_Addr, 0);
    chk({tag, "_wd"}, bus.Mem_Wdata, 0);
    chk({tag, "_rv"}, bus.Rsp_Valid, 0);
    chk({tag, "_rerr"}, bus.Rsp_Err, 0);
    chk({tag, "_op"}, Lw_Sw_OP, 0);
    chk({tag, "_bl"}, Byte_Loc, 0);
    chk({tag, "_dmr"}, Data_Mem_Read, 0);
  endtask

  // Entered right after a falling edge (cycle 0). gdly = grant stall cycles,
  // rdly = cycles after the grant cycle at which Mem_Rvalid is driven (-1 = never).
  task automatic access(input string tag, input bit w, input bit [2:0] op,
                        input bit [31:0] addr, input bit [31:0] wd,
                        input int gdly, input int rdly, input bit [31:0] rd,
                        input bit illegal, input bit [3:0] exp_be,
                        input bit [31:0] exp_wd, input bit rst_in_wait);
    exp_t e;
    bit   tmo, saw_req, granted, done;
    int   lat, req_cyc, wcnt;
    tmo = !illegal && (rdly < 0 || rdly > TO);
    lat = illegal ? 1 : (tmo ? 1 + gdly + TO + 1 : 1 + gdly + rdly + 1);
    if (!illegal && !w && !tmo) dmr_model = rd;
    e.err = illegal || tmo;
    e.op  = op;
    e.bl  = addr[1:0];
    e.dmr = dmr_model;
    sb.push_back(e);

    chk({tag, "_ready"}, bus.Req_Ready, 1);
    bus.Req_Valid = 1'b1;
    bus.Req_Write = w;
    bus.Req_Op    = op;
    bus.Req_Addr  = addr;
    bus.Req_Wdata = wd;
    @(negedge Clk);
    bus.Req_Valid = 1'b0;
    bus.Req_Wdata = $urandom;
    saw_req = 0; granted = 0; done = 0; req_cyc = 0; wcnt = 0;
    for (int c = 1; c <= 300 && !done; c++) begin
      bus.Mem_Gnt    = 1'b0;
      bus.Mem_Rvalid = 1'b0;
      bus.Mem_Rdata  = $urandom;
      if (bus.Rsp_Valid) begin
        chk({tag, "_lat"}, c, lat);
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) e = sb.pop_front();
        chk({tag, "_err"}, bus.Rsp_Err, e.err);
        chk({tag, "_op"}, Lw_Sw_OP, e.op);
        chk({tag, "_bl"}, Byte_Loc, e.bl);
        chk({tag, "_dmr"}, Data_Mem_Read, e.dmr);
        chk({tag, "_mem_traffic"}, saw_req, !illegal);
        if (!illegal) chk({tag, "_req_cycles"}, req_cyc, gdly + 1);
        @(negedge Clk);
        chk({tag, "_rv_pulse"}, bus.Rsp_Valid, 0);
        chk({tag, "_ready_after"}, bus.Req_Ready, 1);
        done = 1;
      end else if (bus.Mem_Req) begin
        saw_req = 1;
        req_cyc++;
        chk({tag, "_maddr"}, bus.Mem_Addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, bus.Mem_Be, exp_be);
        chk({tag, "_we"}, bus.Mem_We, w);
        if (w) chk({tag, "_wd"}, bus.Mem_Wdata, exp_wd);
        if (req_cyc > gdly) begin
          bus.Mem_Gnt = 1'b1;
          granted     = 1;
        end
        @(negedge Clk);
      end else begin
        if (granted) begin
          wcnt++;
          if (rst_in_wait) begin
            #2 Rst_N = 1'b0;
            #1 chk_reset_outputs({tag, "_midrst"});
            void'(sb.pop_front());
            dmr_model = '0;
            @(negedge Clk);
            chk({tag, "_no_rsp_in_rst"}, bus.Rsp_Valid, 0);
            Rst_N = 1'b1;
            done  = 1;
          end else if (wcnt == rdly) begin
            bus.Mem_Rvalid = 1'b1;
            bus.Mem_Rdata  = rd;
          end
        end
        if (!done) @(negedge Clk);
      end
    end
    bus.Mem_Gnt    = 1'b0;
    bus.Mem_Rvalid = 1'b0;
    if (!done) chk({tag, "_completed_in_budget"}, 0, 1);
  endtask

  initial begin
    Rst_N          = 1'b0;
    bus.Req_Valid  = 1'b0;
    bus.Req_Write  = 1'b0;
    bus.Req_Op     = '0;
    bus.Req_Addr   = '0;
    bus.Req_Wdata  = '0;
    bus.Mem_Gnt    = 1'b0;
    bus.Mem_Rvalid = 1'b0;
    bus.Mem_Rdata  = '0;
    #3 chk_reset_outputs("reset");
    repeat (2) @(negedge Clk);
    Rst_N = 1'b1;
    @(negedge Clk);

    //      tag        w  op    addr          wdata         g  r   rdata         ill be       wdata_exp     rst
    access("lw",       0, 3'd2, 32'h100,      32'h0,        0, 1,  32'hDEADBEEF, 0, 4'hF,    32'h0,        0);
    access("sb",       1, 3'd0, 32'h203,      32'h000000A5, 0, 1,  32'h0,        0, 4'b1000, 32'hA5A5A5A5, 0);
    access("sb_l0",    1, 3'd0, 32'h204,      32'h0000003C, 1, 1,  32'h0,        0, 4'b0001, 32'h3C3C3C3C, 0);
    access("sh",       1, 3'd1, 32'h202,      32'h0000C3D2, 0, 1,  32'h0,        0, 4'b1100, 32'hC3D2C3D2, 0);
    access("sh_lo",    1, 3'd1, 32'h300,      32'hFFFF1234, 0, 2,  32'h0,        0, 4'b0011, 32'h12341234, 0);
    access("sw",       1, 3'd2, 32'h10,       32'h12345678, 0, 1,  32'h0,        0, 4'hF,    32'h12345678, 0);
    access("lh_mis",   0, 3'd1, 32'h201,      32'h0,        0, 1,  32'h0,        1, 4'hF,    32'h0,        0);
    access("ld_op6",   0, 3'd6, 32'h200,      32'h0,        0, 1,  32'h0,        1, 4'hF,    32'h0,        0);
    access("st_op3",   1, 3'd3, 32'h200,      32'h0,        0, 1,  32'h0,        1, 4'hF,    32'h0,        0);
    access("sw_mis",   1, 3'd2, 32'h202,      32'h0,        0, 1,  32'h0,        1, 4'hF,    32'h0,        0);
    access("lw_mis",   0, 3'd2, 32'h101,      32'h0,        0, 1,  32'h0,        1, 4'hF,    32'h0,        0);
    access("lbu_stl",  0, 3'd3, 32'h1,        32'h0,        3, 2,  32'h00000080, 0, 4'hF,    32'h0,        0);
    access("lw_tmo",   0, 3'd2, 32'h40,       32'h0,        0, -1, 32'h0,        0, 4'hF,    32'h0,        0);

    // Late response while idle must be ignored
    bus.Mem_Rvalid = 1'b1;
    bus.Mem_Rdata  = 32'h55AA55AA;
    @(negedge Clk);
    chk("late_rv_rsp", bus.Rsp_Valid, 0);
    chk("late_rv_dmr", Data_Mem_Read, dmr_model);
    chk("late_rv_ready", bus.Req_Ready, 1);
    bus.Mem_Rvalid = 1'b0;
    @(negedge Clk);
    chk("late_rv_rsp2", bus.Rsp_Valid, 0);

    access("lhu_edge", 0, 3'd4, 32'h6,        32'h0,        0, TO, 32'hCAFEF00D, 0, 4'hF,    32'h0,        0);
    access("lh_stl",   0, 3'd1, 32'h2,        32'h0,        2, 3,  32'h0000BEEF, 0, 4'hF,    32'h0,        0);
    access("lw_rst",   0, 3'd2, 32'h80,       32'h0,        0, 1,  32'h11111111, 0, 4'hF,    32'h0,        1);
    access("lb_post",  0, 3'd0, 32'h3,        32'h0,        0, 1,  32'h7F000000, 0, 4'hF,    32'h0,        0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
